// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipe_stage_skid instance.
// Valid/ready rule: a beat moves on a rising edge exactly when valid and
// ready are both 1 in the cycle before it. The source holds its payload
// stable while valid=1 and ready=0. Ready may be 1 while valid is 0.
// master = upstream/downstream side driving the stage, slave = the stage.
interface pipe_stage_skid_if #(
  parameter int PAYLOAD_W = 39,
  parameter int CNT_W     = 8
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [1:0]           occupancy;
  logic [CNT_W-1:0]     stall_cnt;
  logic [1:0]           dbg_state;

  modport master (
    output flush, in_valid, in_payload, out_ready,
    input  in_ready, out_valid, out_payload, occupancy, stall_cnt, dbg_state
  );

  modport slave (
    input  flush, in_valid, in_payload, out_ready,
    output in_ready, out_valid, out_payload, occupancy, stall_cnt, dbg_state
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush that squashes the control field,
// and a saturating stall counter. CTRL_W must lie in 1..PAYLOAD_W.
module pipe_stage_skid #(
  parameter int PAYLOAD_W = 39,
  parameter int CTRL_W    = 3,
  parameter bit SKID_EN   = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_skid_if.slave bus
);

  // EMPTY: no entry, ONE: main held, FULL: main and skid held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [PAYLOAD_W-1:0] ONES      = '1;
  localparam logic [PAYLOAD_W-1:0] CTRL_MASK = ONES >> (PAYLOAD_W - CTRL_W);

  state_t               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]     stall_q;
  logic                 accept, drain;
  logic                 out_valid, in_ready;

  assign out_valid = (state_q != ST_EMPTY);
  // With the skid buffer, ready depends only on registered state so there
  // is no combinational path from out_ready back to in_ready.
  assign in_ready  = SKID_EN ? (state_q != ST_FULL)
                             : (bus.out_ready | (state_q == ST_EMPTY));
  assign accept    = bus.in_valid & in_ready;
  assign drain     = out_valid & bus.out_ready;

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_payload = main_q;
  assign bus.occupancy   = (state_q == ST_FULL) ? 2'd2 :
                           (state_q == ST_ONE)  ? 2'd1 : 2'd0;
  assign bus.stall_cnt   = stall_q;
  assign bus.dbg_state   = state_q;

  // State and payload registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and payload moves; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (SKID_EN) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = bus.in_payload;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = bus.in_payload;
          end else if (accept) begin
            skid_d  = bus.in_payload;
            state_d = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end else begin
      if (accept) begin
        main_d  = bus.in_payload;
        state_d = ST_ONE;
      end else if (drain) begin
        state_d = ST_EMPTY;
      end
    end
    if (bus.flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q & ~CTRL_MASK;
      skid_d  = skid_q & ~CTRL_MASK;
    end
  end

  // Stall counter: counts cycles where a held beat is refused, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (out_valid && !bus.out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid instance, narrow-counter skid
// instance for saturation, and a single-register instance.
module tb_pipe_stage_skid;

  localparam int W = 39;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  pipe_stage_skid_if #(.PAYLOAD_W(W), .CNT_W(8)) if_a ();
  pipe_stage_skid_if #(.PAYLOAD_W(W), .CNT_W(4)) if_s ();
  pipe_stage_skid_if #(.PAYLOAD_W(W), .CNT_W(8)) if_n ();

  pipe_stage_skid #(.PAYLOAD_W(W), .CTRL_W(3), .SKID_EN(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  pipe_stage_skid #(.PAYLOAD_W(W), .CTRL_W(3), .SKID_EN(1'b1), .CNT_W(4)) u_s (
    .clk(clk), .rst(rst), .bus(if_s.slave));
  pipe_stage_skid #(.PAYLOAD_W(W), .CTRL_W(3), .SKID_EN(1'b0), .CNT_W(8)) u_n (
    .clk(clk), .rst(rst), .bus(if_n.slave));

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [W-1:0] pa, pb, pc, px, base;
    logic [3:0]   sat_exp;

    if_a.flush = 0; if_a.in_valid = 0; if_a.in_payload = '0; if_a.out_ready = 0;
    if_s.flush = 0; if_s.in_valid = 0; if_s.in_payload = '0; if_s.out_ready = 0;
    if_n.flush = 0; if_n.in_valid = 0; if_n.in_payload = '0; if_n.out_ready = 0;

    // Reset values
    #3;
    chk("rst_out_valid", 64'(if_a.out_valid), 64'd0);
    chk("rst_payload",   64'(if_a.out_payload), 64'd0);
    chk("rst_occ",       64'(if_a.occupancy), 64'd0);
    chk("rst_in_ready",  64'(if_a.in_ready), 64'd1);
    chk("rst_stall",     64'(if_a.stall_cnt), 64'd0);
    chk("rst_n_in_ready", 64'(if_n.in_ready), 64'd1);
    tick();
    rst = 1'b1;
    tick();

    // Single beat
    pa = 39'h12_3456_789A;
    if_a.in_valid = 1; if_a.in_payload = pa; if_a.out_ready = 1;
    tick();
    if_a.in_valid = 0;
    chk("beat_valid", 64'(if_a.out_valid), 64'd1);
    chk("beat_payload", 64'(if_a.out_payload), 64'(pa));
    chk("beat_occ1", 64'(if_a.occupancy), 64'd1);
    tick();
    chk("beat_drained", 64'(if_a.out_valid), 64'd0);
    chk("beat_occ0", 64'(if_a.occupancy), 64'd0);

    // Backpressure fill: A to main, B to skid, C refused
    pa = 39'h00_0000_0A01; pb = 39'h00_0000_0B02; pc = 39'h00_0000_0C03;
    if_a.out_ready = 0; if_a.in_valid = 1; if_a.in_payload = pa;
    tick();
    chk("bp_occ1", 64'(if_a.occupancy), 64'd1);
    chk("bp_rdy1", 64'(if_a.in_ready), 64'd1);
    if_a.in_payload = pb;
    tick();
    chk("bp_occ2", 64'(if_a.occupancy), 64'd2);
    chk("bp_rdy_full", 64'(if_a.in_ready), 64'd0);
    chk("bp_stall1", 64'(if_a.stall_cnt), 64'd1);
    if_a.in_payload = pc;
    tick();
    chk("bp_hold_a", 64'(if_a.out_payload), 64'(pa));
    chk("bp_occ_hold", 64'(if_a.occupancy), 64'd2);
    chk("bp_stall2", 64'(if_a.stall_cnt), 64'd2);
    if_a.out_ready = 1;
    #1;
    chk("bp_rdy_no_comb", 64'(if_a.in_ready), 64'd0);
    tick();
    chk("bp_out_b", 64'(if_a.out_payload), 64'(pb));
    chk("bp_occ_after_a", 64'(if_a.occupancy), 64'd1);
    tick();
    if_a.in_valid = 0;
    chk("bp_out_c", 64'(if_a.out_payload), 64'(pc));
    chk("bp_occ_c", 64'(if_a.occupancy), 64'd1);
    tick();
    chk("bp_empty", 64'(if_a.out_valid), 64'd0);
    chk("bp_stall_final", 64'(if_a.stall_cnt), 64'd2);

    // Streaming 100 beats
    base = 39'h40_0000_0000;
    if_a.in_valid = 1; if_a.out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      if_a.in_payload = base + W'(i);
      tick();
      chk("stream_payload", 64'(if_a.out_payload), 64'(base + W'(i)));
      chk("stream_occ", 64'(if_a.occupancy), 64'd1);
      chk("stream_rdy", 64'(if_a.in_ready), 64'd1);
    end
    if_a.in_valid = 0;
    tick();
    chk("stream_end", 64'(if_a.occupancy), 64'd0);

    // Flush in FULL with a concurrent input beat
    pa = 39'h0A_AAAA_AAAF; pb = 39'h0B_BBBB_BBBF; px = 39'h05_5555_5555;
    if_a.out_ready = 0; if_a.in_valid = 1; if_a.in_payload = pa;
    tick();
    if_a.in_payload = pb;
    tick();
    chk("fl_full", 64'(if_a.occupancy), 64'd2);
    chk("fl_stall_pre", 64'(if_a.stall_cnt), 64'd3);
    if_a.flush = 1; if_a.in_payload = px;
    tick();
    if_a.flush = 0; if_a.in_valid = 0;
    chk("fl_valid", 64'(if_a.out_valid), 64'd0);
    chk("fl_occ", 64'(if_a.occupancy), 64'd0);
    chk("fl_rdy", 64'(if_a.in_ready), 64'd1);
    chk("fl_ctrl_clear", 64'(if_a.out_payload), 64'(39'h0A_AAAA_AAA8));
    chk("fl_stall_kept", 64'(if_a.stall_cnt), 64'd4);
    if_a.out_ready = 1;
    tick();
    chk("fl_no_ghost", 64'(if_a.out_valid), 64'd0);
    chk("fl_no_capture", 64'(if_a.out_payload), 64'(39'h0A_AAAA_AAA8));

    // Async reset while FULL
    if_a.out_ready = 0; if_a.in_valid = 1; if_a.in_payload = 39'h00_0000_1111;
    tick();
    if_a.in_payload = 39'h00_0000_2222;
    tick();
    if_a.in_valid = 0;
    chk("ar_full", 64'(if_a.occupancy), 64'd2);
    chk("ar_stall_pre", 64'(if_a.stall_cnt), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(if_a.out_valid), 64'd0);
    chk("ar_occ", 64'(if_a.occupancy), 64'd0);
    chk("ar_stall", 64'(if_a.stall_cnt), 64'd0);
    chk("ar_payload", 64'(if_a.out_payload), 64'd0);
    chk("ar_rdy", 64'(if_a.in_ready), 64'd1);
    tick();
    rst = 1'b1;
    tick();

    // Saturation on a 4-bit counter
    if_s.in_valid = 1; if_s.in_payload = 39'h00_0000_0777; if_s.out_ready = 0;
    tick();
    if_s.in_valid = 0;
    chk("sat_start", 64'(if_s.stall_cnt), 64'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      sat_exp = (k > 15) ? 4'd15 : 4'(k);
      chk("sat_cnt", 64'(if_s.stall_cnt), 64'(sat_exp));
    end

    // Single-register stage: combinational in_ready
    if_n.in_valid = 1; if_n.in_payload = 39'h00_0000_0D0D; if_n.out_ready = 0;
    #1;
    chk("ns_rdy_empty", 64'(if_n.in_ready), 64'd1);
    tick();
    chk("ns_occ1", 64'(if_n.occupancy), 64'd1);
    chk("ns_rdy_block", 64'(if_n.in_ready), 64'd0);
    chk("ns_payload_d", 64'(if_n.out_payload), 64'(39'h00_0000_0D0D));
    if_n.out_ready = 1;
    #1;
    chk("ns_rdy_comb", 64'(if_n.in_ready), 64'd1);
    base = 39'h20_0000_0E00;
    for (int i = 0; i < 10; i++) begin
      if_n.in_payload = base + W'(i);
      tick();
      chk("ns_stream", 64'(if_n.out_payload), 64'(base + W'(i)));
      chk("ns_stream_occ", 64'(if_n.occupancy), 64'd1);
    end
    if_n.out_ready = 0; if_n.in_payload = 39'h00_0000_0F0F;
    #1;
    chk("ns_rdy_drop", 64'(if_n.in_ready), 64'd0);
    tick();
    chk("ns_no_take", 64'(if_n.out_payload), 64'(base + W'(9)));
    if_n.in_valid = 0; if_n.out_ready = 1;
    tick();
    chk("ns_empty", 64'(if_n.occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
